// File: rtl/regfile_sb.sv
// Register file with zero register, optional write-to-read forwarding and a
// per-register busy scoreboard that produces the decode-stage stall.
module regfile_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_regWr,
  input  logic [ADDR_W-1:0] i_rw,
  input  logic [DATA_W-1:0] i_busW,
  input  logic [ADDR_W-1:0] i_ra,
  input  logic [ADDR_W-1:0] i_rb,
  input  logic              i_use_a,
  input  logic              i_use_b,
  input  logic              i_resv,
  input  logic [ADDR_W-1:0] i_resv_rd,
  output logic [DATA_W-1:0] o_busA,
  output logic [DATA_W-1:0] o_busB,
  output logic              o_stall,
  output logic [ADDR_W:0]   o_pending
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [CNT_W-1:0]  pending_q;
  logic [CNT_W-1:0]  pending_d;

  logic wr_en_c;
  logic resv_en_c;
  logic fwd_a_c;
  logic fwd_b_c;
  logic haz_a_c;
  logic haz_b_c;
  logic rel_eff_c;
  logic res_eff_c;

  assign wr_en_c   = i_regWr && (i_rw != '0);
  assign resv_en_c = i_resv && (i_resv_rd != '0);

  // Forwarding is suppressed while reset is low: the in-flight write is discarded.
  assign fwd_a_c = BYPASS && i_rst_n && i_regWr && (i_ra != '0) && (i_rw == i_ra);
  assign fwd_b_c = BYPASS && i_rst_n && i_regWr && (i_rb != '0) && (i_rw == i_rb);

  always_comb begin
    o_busA = '0;
    o_busB = '0;
    if (i_ra != '0) o_busA = fwd_a_c ? i_busW : regs_q[i_ra];
    if (i_rb != '0) o_busB = fwd_b_c ? i_busW : regs_q[i_rb];
  end

  assign haz_a_c = busy_q[i_ra] && (i_ra != '0) && !fwd_a_c;
  assign haz_b_c = busy_q[i_rb] && (i_rb != '0) && !fwd_b_c;
  assign o_stall = (i_use_a && haz_a_c) || (i_use_b && haz_b_c);

  // A release only counts if it actually clears a bit that the same cycle's reserve does not re-set.
  assign rel_eff_c = wr_en_c && busy_q[i_rw] && !(resv_en_c && (i_resv_rd == i_rw));
  assign res_eff_c = resv_en_c && !busy_q[i_resv_rd];

  always_comb begin
    busy_d    = busy_q;
    pending_d = pending_q;
    if (wr_en_c)   busy_d[i_rw]      = 1'b0;
    if (resv_en_c) busy_d[i_resv_rd] = 1'b1;
    busy_d[0] = 1'b0;
    if (res_eff_c && !rel_eff_c)      pending_d = pending_q + CNT_W'(1);
    else if (rel_eff_c && !res_eff_c) pending_d = pending_q - CNT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_en_c) begin
      regs_q[i_rw] <= i_busW;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q    <= '0;
      pending_q <= '0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

  assign o_pending = pending_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Vector-table bench for regfile_sb: a forwarding and a non-forwarding instance
// share stimulus; expected outputs travel through a queue to the sample point.
module tb_regfile_sb;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_regWr;
  logic [ADDR_W-1:0] i_rw;
  logic [DATA_W-1:0] i_busW;
  logic [ADDR_W-1:0] i_ra;
  logic [ADDR_W-1:0] i_rb;
  logic              i_use_a;
  logic              i_use_b;
  logic              i_resv;
  logic [ADDR_W-1:0] i_resv_rd;

  logic [DATA_W-1:0] bus_a1, bus_b1, bus_a0, bus_b0;
  logic              stall1, stall0;
  logic [ADDR_W:0]   pend1, pend0;

  int tests = 0;
  int fails = 0;

  always #5 i_clk = ~i_clk;

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b1)) u_byp (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_regWr(i_regWr), .i_rw(i_rw), .i_busW(i_busW),
    .i_ra(i_ra), .i_rb(i_rb), .i_use_a(i_use_a), .i_use_b(i_use_b),
    .i_resv(i_resv), .i_resv_rd(i_resv_rd),
    .o_busA(bus_a1), .o_busB(bus_b1), .o_stall(stall1), .o_pending(pend1)
  );

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b0)) u_nob (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_regWr(i_regWr), .i_rw(i_rw), .i_busW(i_busW),
    .i_ra(i_ra), .i_rb(i_rb), .i_use_a(i_use_a), .i_use_b(i_use_b),
    .i_resv(i_resv), .i_resv_rd(i_resv_rd),
    .o_busA(bus_a0), .o_busB(bus_b0), .o_stall(stall0), .o_pending(pend0)
  );

  typedef struct {
    logic        wr;
    logic [4:0]  rw;
    logic [31:0] bw;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        ua;
    logic        ub;
    logic        rs;
    logic [4:0]  rd;
    logic [31:0] ea1;
    logic [31:0] eb1;
    logic [31:0] ea0;
    logic [31:0] eb0;
    logic        es1;
    logic        es0;
    logic [5:0]  ep;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [4:0] rw, input logic [31:0] bw,
                              input logic [4:0] ra, input logic [4:0] rb,
                              input logic ua, input logic ub, input logic rs, input logic [4:0] rd,
                              input logic [31:0] ea1, input logic [31:0] eb1,
                              input logic [31:0] ea0, input logic [31:0] eb0,
                              input logic es1, input logic es0, input logic [5:0] ep);
    vec_t v;
    v.wr = wr; v.rw = rw; v.bw = bw; v.ra = ra; v.rb = rb;
    v.ua = ua; v.ub = ub; v.rs = rs; v.rd = rd;
    v.ea1 = ea1; v.eb1 = eb1; v.ea0 = ea0; v.eb0 = eb0;
    v.es1 = es1; v.es0 = es0; v.ep = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    i_regWr = 1'b0; i_rw = '0; i_busW = '0; i_ra = '0; i_rb = '0;
    i_use_a = 1'b0; i_use_b = 1'b0; i_resv = 1'b0; i_resv_rd = '0;
  endtask

  task automatic apply(input vec_t v);
    i_regWr = v.wr; i_rw = v.rw; i_busW = v.bw; i_ra = v.ra; i_rb = v.rb;
    i_use_a = v.ua; i_use_b = v.ub; i_resv = v.rs; i_resv_rd = v.rd;
  endtask

  vec_t tbl[$];
  vec_t sb[$];
  vec_t e;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Columns: wr rw bw ra rb ua ub rs rd | busA busB (fwd) busA busB (no fwd) stall(fwd) stall(no fwd) pending
    tbl.push_back(mk(1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 5, 7, 0, 0, 0, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 32'h12345678, 0, 5, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 9, 32'hA5A5A5A5, 5, 9, 0, 0, 0, 0, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hDEADBEEF, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 9, 9, 0, 0, 0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 3, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 9, 3, 1, 1, 0, 0, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0, 1, 1, 1));
    tbl.push_back(mk(1, 3, 32'h33, 3, 0, 1, 0, 0, 0, 32'h33, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 3, 0, 1, 0, 0, 0, 32'h33, 0, 32'h33, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4, 32'h44, 4, 0, 1, 0, 1, 4, 32'h44, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 4, 0, 1, 0, 0, 0, 32'h44, 0, 32'h44, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 4, 0, 0, 0, 1, 0, 32'h44, 0, 32'h44, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 2, 32'h11, 2, 0, 0, 0, 0, 0, 32'h11, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 2, 0, 0, 0, 1, 2, 32'h11, 0, 32'h11, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 2, 0, 0, 0, 1, 6, 32'h11, 0, 32'h11, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 2, 6, 1, 1, 0, 0, 32'h11, 0, 32'h11, 0, 1, 1, 3));
    tbl.push_back(mk(1, 4, 32'h55, 4, 0, 1, 0, 1, 7, 32'h55, 0, 32'h44, 0, 0, 1, 3));
    tbl.push_back(mk(0, 0, 0, 7, 4, 1, 1, 0, 0, 0, 32'h55, 0, 32'h55, 1, 1, 3));

    // Reset with no reliance on a clock edge: every address must read zero.
    idle();
    i_rst_n = 1'b0;
    i_use_a = 1'b1;
    i_use_b = 1'b1;
    #1;
    chk("reset pending fwd", 32'(pend1), 0);
    chk("reset pending nofwd", 32'(pend0), 0);
    for (int a = 1; a < 32; a++) begin
      i_ra = 5'(a);
      i_rb = 5'(32 - a);
      #1;
      chk($sformatf("reset r%0d busA", a), bus_a1, 0);
      chk($sformatf("reset r%0d busB", 32 - a), bus_b0, 0);
      chk($sformatf("reset r%0d stall", a), 32'(stall1), 0);
    end
    idle();
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge i_clk);
      #1;
      apply(tbl[i]);
      sb.push_back(tbl[i]);
      @(negedge i_clk);
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL v%0d scoreboard: got empty queue expected entry", i);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d busA fwd", i), bus_a1, e.ea1);
        chk($sformatf("v%0d busB fwd", i), bus_b1, e.eb1);
        chk($sformatf("v%0d busA nofwd", i), bus_a0, e.ea0);
        chk($sformatf("v%0d busB nofwd", i), bus_b0, e.eb0);
        chk($sformatf("v%0d stall fwd", i), 32'(stall1), 32'(e.es1));
        chk($sformatf("v%0d stall nofwd", i), 32'(stall0), 32'(e.es0));
        chk($sformatf("v%0d pending fwd", i), 32'(pend1), 32'(e.ep));
        chk($sformatf("v%0d pending nofwd", i), 32'(pend0), 32'(e.ep));
      end
    end

    // Reset between edges with a write and a reserve in flight; r2, r6, r7 busy.
    @(posedge i_clk);
    #1;
    i_regWr = 1'b1; i_rw = 5'd6; i_busW = 32'h99;
    i_ra = 5'd2; i_rb = 5'd2; i_use_a = 1'b1; i_use_b = 1'b1;
    i_resv = 1'b1; i_resv_rd = 5'd5;
    #1;
    chk("midrst pre stall", 32'(stall1), 1);
    chk("midrst pre busA", bus_a1, 32'h11);
    i_rst_n = 1'b0;
    #1;
    chk("midrst pending fwd", 32'(pend1), 0);
    chk("midrst pending nofwd", 32'(pend0), 0);
    chk("midrst busA fwd", bus_a1, 0);
    chk("midrst busB nofwd", bus_b0, 0);
    chk("midrst stall fwd", 32'(stall1), 0);
    chk("midrst stall nofwd", 32'(stall0), 0);
    @(posedge i_clk);
    @(negedge i_clk);
    idle();
    i_rst_n = 1'b1;
    i_ra = 5'd6; i_rb = 5'd9; i_use_a = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("postrst r6 busA", bus_a1, 0);
    chk("postrst r9 busB", bus_b1, 0);
    chk("postrst pending", 32'(pend1), 0);
    chk("postrst stall", 32'(stall1), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised register file with a hazard scoreboard.
- Two combinational read ports, one synchronous write port, and a hardwired zero register at address 0.
- Optional write-to-read bypass.
- Per-register busy bits are set at issue and cleared at writeback. They drive a stall output for the pipelined core's decode stage.
- Asynchronous reset clears every register and every busy bit.

Parameters:
DATA_W, 32, data width of each register and bus
ADDR_W, 5, register address width; depth = 2**ADDR_W (register 0 included, hardwired to zero)
BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads return the pre-write array value

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_regWr  in  1  write enable (writeback stage)
i_rw  in  ADDR_W  write address
i_busW  in  DATA_W  write data
i_ra  in  ADDR_W  read address A
i_rb  in  ADDR_W  read address B
i_use_a  in  1  decode actually consumes port A
i_use_b  in  1  decode actually consumes port B
i_resv  in  1  reserve destination (instruction issued this cycle)
i_resv_rd  in  ADDR_W  destination being reserved
o_busA  out  DATA_W  read data A
o_busB  out  DATA_W  read data B
o_stall  out  1  read-after-write hazard on a used source
o_pending  out  ADDR_W+1  number of busy registers

Behaviour:
- Reset (i_rst_n=0, asynchronous, no clock needed):
  - All registers 1..2**ADDR_W-1 become 0.
  - All busy bits become 0; o_pending=0; o_stall=0.
  - Outputs then reflect the cleared array.
  - Reset asserted mid-operation discards any in-flight write or reserve from that cycle.
  - Deassertion is synchronous to the design's reset synchroniser (not part of this block).
- Write:
  - On the rising i_clk edge with i_regWr=1 and i_rw!=0, registers[i_rw] <= i_busW.
  - A write to address 0 is ignored (no state change, no busy change).
- Read (combinational, zero latency):
  - Address 0 always returns 0.
  - If BYPASS=1, i_regWr=1, and i_ra==i_rw!=0, then o_busA=i_busW. Same rule for port B.
  - Otherwise the port returns the array value.
  - If BYPASS=0, a same-cycle write becomes visible after the edge.
- Scoreboard:
  - One busy bit per register; bit 0 is constant 0.
  - Release: i_regWr=1 with i_rw!=0 clears busy[i_rw] at the edge.
  - Reserve: i_resv=1 with i_resv_rd!=0 sets busy[i_resv_rd] at the edge.
  - Same register released and reserved in one cycle: reserve wins, bit stays 1. o_pending is unchanged for that pair.
  - Reserve of an already-busy register: bit stays 1, o_pending unchanged. Multiple outstanding writers to one register are not tracked.
  - Release of a non-busy register: no effect.
- o_pending: registered count of set busy bits, updated on the same edge as the bits. Net change per cycle is -1, 0 or +1. Maximum is 2**ADDR_W-1.
- o_stall (combinational): (i_use_a & hazA) | (i_use_b & hazB).
  - hazA = busy[i_ra] & (i_ra!=0) & ~(BYPASS & i_regWr & i_rw==i_ra).
  - hazB is the same with i_rb.
  - With BYPASS=0 a same-cycle release does not remove the stall; stall drops the next cycle.
- o_stall does not gate i_resv. Decode must not assert i_resv while o_stall=1; the block does not check this.

Test Plan:
- Reset then read: pulse i_rst_n low with no clock edge -> o_busA=o_busB=0 for every address 1..31; o_pending=0; o_stall=0.
- Write/read: write 0xDEADBEEF to r5, then r7 -> i_ra=5 gives o_busA=0xDEADBEEF. Write 0x12345678 to r0 -> i_ra=0 still gives 0.
- Bypass: BYPASS=1, i_regWr=1, i_rw=9, i_busW=0xA5A5A5A5, i_rb=9 in the same cycle -> o_busB=0xA5A5A5A5 before the edge. With BYPASS=0 -> old value until after the edge.
- Scoreboard hazard:
  - Reserve r3 -> next cycle o_pending=1.
  - i_ra=3, i_use_a=1 -> o_stall=1; with i_use_a=0 -> o_stall=0.
  - Writeback r3 (BYPASS=1) -> o_stall=0 in that cycle; o_pending=0 after the edge.
- Simultaneous reserve/release: r4 busy; same cycle i_regWr with i_rw=4 and i_resv with i_resv_rd=4 -> busy[4] stays 1, o_pending unchanged. Reserve r0 -> o_pending unchanged.
- Reset mid-operation: r2 and r6 busy, r2=0x11, with a write pending -> assert i_rst_n=0 between edges -> o_pending=0, r2 reads 0, o_stall=0 immediately.
